// File: rtl/hash_comparator_mc_pkg.sv
// Shared definitions for the multi-channel hash comparator: FSM state
// encodings, derived-size helpers and a parameter sanity check.
package hash_cmp_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_DRAIN   = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_SELECT  = 3'd2;
    localparam state_t ST_COMPARE = 3'd3;
    localparam state_t ST_REPORT  = 3'd4;

    // Number of target write-port words that make up one full target.
    function automatic int calc_nw(input int hash_w, input int tgt_w);
        return hash_w / tgt_w;
    endfunction

    // Number of compare chunks per hash.
    function automatic int calc_nc(input int hash_w, input int cmp_w);
        return hash_w / cmp_w;
    endfunction

    // Index width for a set of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when the parameter set describes a buildable comparator.
    function automatic bit params_ok(input int hash_w, input int tgt_w,
                                     input int cmp_w, input int n_ch,
                                     input int cnt_w);
        return (hash_w > 0) && (tgt_w > 0) && (cmp_w > 0) &&
               (tgt_w <= hash_w) && (cmp_w <= hash_w) &&
               ((hash_w % tgt_w) == 0) && ((hash_w % cmp_w) == 0) &&
               (n_ch >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/hash_comparator_mc_rr_pick.sv
// Combinational round-robin finder: returns the first requesting index at or
// after the pointer, wrapping modulo N.
module rr_pick
    import hash_cmp_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             any_valid
);

    // Scan from the farthest offset back to the pointer so the closest
    // requester after the pointer is the last (winning) assignment.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hash_comparator_mc.sv
// Multi-channel miner comparator: loads a wide target over a narrow port,
// services N_CH first-word-fall-through hash FIFOs round-robin and compares
// each head against the target MSB-first, one chunk per cycle, exiting as
// soon as the outcome is known. Golden hashes (hash < target) are reported
// with their channel and sequence number.
module hash_comparator_mc
    import hash_cmp_pkg::*;
#(
    parameter int HASH_W = 256,
    parameter int TGT_W  = 32,
    parameter int CMP_W  = 64,
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic [TGT_W-1:0]         target,
    input  logic                     target_we,
    input  logic                     heavy_hash_all_empty,
    input  logic [N_CH*HASH_W-1:0]   hash_out,
    input  logic [N_CH-1:0]          hash_empty,
    output logic [N_CH-1:0]          hash_re,
    output logic                     stop_ack,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [idx_w(N_CH)-1:0]   result_ch,
    output logic [CNT_W-1:0]         result_seq,
    output logic [CNT_W-1:0]         hash_count
);

    localparam int NW   = calc_nw(HASH_W, TGT_W);
    localparam int NC   = calc_nc(HASH_W, CMP_W);
    localparam int CH_W = idx_w(N_CH);
    localparam int KC_W = idx_w(NC);
    localparam int WC_W = $clog2(NW + 1);

    if (!params_ok(HASH_W, TGT_W, CMP_W, N_CH, CNT_W)) begin : g_bad_params
        $error("hash_comparator_mc: HASH_W must be a multiple of TGT_W and CMP_W, N_CH >= 1");
    end

    state_t             state;
    logic [HASH_W-1:0]  target_reg;
    logic [HASH_W-1:0]  target_shift;
    logic [WC_W-1:0]    word_cnt;
    logic [KC_W-1:0]    chunk;
    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    cur_ch;
    logic [CH_W-1:0]    next_ch;
    logic [CH_W-1:0]    grant;
    logic               any_valid;
    logic               cont_mode;
    logic [CMP_W-1:0]   h_slice;
    logic [CMP_W-1:0]   t_slice;
    logic               chunk_lt;
    logic               chunk_gt;
    logic               last_chunk;
    logic               decide;
    logic [CNT_W-1:0]   count_inc;

    rr_pick #(
        .N     (N_CH),
        .IDX_W (CH_W)
    ) u_rr_pick (
        .req       (~hash_empty),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    // New target word enters at the top; earlier words slide toward the LSB.
    always_comb begin
        target_shift = target_reg >> TGT_W;
        target_shift[HASH_W-1 -: TGT_W] = target;
    end

    // Chunk compare of the current head against the target, MSB chunk first.
    always_comb begin
        int h_base;
        int t_base;
        t_base     = (HASH_W - 1) - int'(chunk) * CMP_W;
        h_base     = int'(cur_ch) * HASH_W + t_base;
        h_slice    = hash_out[h_base -: CMP_W];
        t_slice    = target_reg[t_base -: CMP_W];
        chunk_lt   = h_slice < t_slice;
        chunk_gt   = h_slice > t_slice;
        last_chunk = chunk == KC_W'(NC - 1);
        decide     = (state == ST_COMPARE) && !stop &&
                     (chunk_lt || chunk_gt || last_chunk);
        count_inc  = hash_count + CNT_W'(1);
        next_ch    = (cur_ch == CH_W'(N_CH - 1)) ? '0 : cur_ch + 1'b1;
    end

    // FIFO pops and drain acknowledge follow directly from the current state.
    always_comb begin
        hash_re  = '0;
        stop_ack = 1'b0;
        case (state)
            ST_DRAIN: begin
                if (heavy_hash_all_empty) begin
                    stop_ack = 1'b1;
                end else begin
                    hash_re = ~hash_empty;
                end
            end
            ST_COMPARE: begin
                if (decide) begin
                    hash_re = N_CH'(1) << cur_ch;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with target load, chunk stepping, counting and result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_DRAIN;
            target_reg   <= '0;
            word_cnt     <= '0;
            chunk        <= '0;
            rr_ptr       <= '0;
            cur_ch       <= '0;
            cont_mode    <= 1'b0;
            hash_count   <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_seq   <= '0;
        end else if (stop && (state != ST_DRAIN)) begin
            state        <= ST_DRAIN;
            result_valid <= 1'b0;
        end else begin
            case (state)
                ST_DRAIN: begin
                    if (heavy_hash_all_empty && start && !stop) begin
                        word_cnt     <= '0;
                        hash_count   <= '0;
                        result_valid <= 1'b0;
                        cont_mode    <= continuous;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (word_cnt == WC_W'(NW)) begin
                        state <= ST_SELECT;
                    end else if (target_we) begin
                        target_reg <= target_shift;
                        word_cnt   <= word_cnt + 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (any_valid) begin
                        cur_ch <= grant;
                        chunk  <= '0;
                        state  <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (decide) begin
                        hash_count <= count_inc;
                        rr_ptr     <= next_ch;
                        if (chunk_lt) begin
                            result_valid <= 1'b1;
                            result_ch    <= cur_ch;
                            result_seq   <= count_inc;
                            state        <= ST_REPORT;
                        end else begin
                            state <= ST_SELECT;
                        end
                    end else begin
                        chunk <= chunk + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= cont_mode ? ST_SELECT : ST_DRAIN;
                    end
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end

endmodule

// File: doc/hash_comparator_mc.md
Name: hash_comparator_mc

Overview:
- Parametrised successor of the single-channel miner comparator.
- Loads a HASH_W-bit target over a narrow write port, then arbitrates round-robin across N_CH heavy-hash output FIFOs (first-word-fall-through).
- Compares each head hash against the target MSB-first, CMP_W bits per cycle, with early exit.
- Reports golden hashes (hash < target) with channel ID and sequence number. Stops after the first golden hash, or keeps going in continuous mode.

Parameters:
HASH_W, 256, hash/target width; multiple of TGT_W and CMP_W
TGT_W, 32, target write-port width
CMP_W, 64, bits compared per cycle
N_CH, 4, number of hash FIFO channels (>=1)
CNT_W, 32, width of hash sequence counter

Ports:
clk  in  1  global clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin run (sampled in DRAIN only)
stop  in  1  abort run; highest priority
continuous  in  1  1: keep searching after golden; sampled on leaving DRAIN
target  in  TGT_W  target word
target_we  in  1  target word valid
heavy_hash_all_empty  in  1  all upstream FIFOs empty
hash_out  in  N_CH*HASH_W  FIFO heads; channel c at [c*HASH_W +: HASH_W]
hash_empty  in  N_CH  per-channel empty
hash_re  out  N_CH  per-channel pop, one-hot or zero except in DRAIN
stop_ack  out  1  block idle and upstream drained
result_valid  out  1  golden hash pending
result_ready  in  1  consumer accepts result
result_ch  out  $clog2(N_CH) (min 1)  channel of golden hash
result_seq  out  CNT_W  value of hash_count when golden was found
hash_count  out  CNT_W  hashes compared since start

Behaviour:
- Reset (rst_n=0 at posedge) -> state DRAIN; target_reg, word count, chunk index, RR pointer, hash_count, result_ch and result_seq = 0; result_valid = 0.
- hash_re, stop_ack: combinational from state.
- Derived constants: NW = HASH_W/TGT_W, NC = HASH_W/CMP_W.
- Stop handling: stop=1 in any state except DRAIN -> DRAIN next cycle. No pop that cycle. result_valid is cleared.
- DRAIN:
  - hash_re[c] = !hash_empty[c] for every channel.
  - When heavy_hash_all_empty: stop_ack=1 and hash_re=0.
  - When all_empty && start && !stop: clear word count, hash_count and result_valid; latch continuous -> LOAD.
- LOAD:
  - Each target_we shifts target_reg = {target, target_reg[HASH_W-1:TGT_W]}, so the first word ends least-significant.
  - Word count increments per write; target_we is ignored once the count reaches NW.
  - Count == NW -> SELECT in the next cycle. target_we is ignored in all other states.
- SELECT:
  - Scan channels starting at rr_ptr, wrapping modulo N_CH; pick the first with !hash_empty; latch cur_ch; chunk index = 0 -> COMPARE.
  - All empty -> remain in SELECT.
- COMPARE, per cycle:
  - Compare h = head[HASH_W-1-k*CMP_W -: CMP_W] of cur_ch against the same slice of target_reg (unsigned), k = chunk index.
  - h < t: golden.
  - h > t: not golden.
  - h == t with k < NC-1: k++ and stay.
  - h == t with k == NC-1: not golden (equality is not golden).
  - On decision, same cycle: hash_re[cur_ch]=1; hash_count += 1 (wraps at 2^CNT_W); rr_ptr = cur_ch+1 mod N_CH.
  - Golden: result_valid<=1, result_ch<=cur_ch, result_seq<=post-increment hash_count -> REPORT.
  - Not golden: -> SELECT.
  - Latency: 2 to NC+1 cycles per hash, including SELECT.
  - The head must stay stable while not popped (FWFT contract). hash_empty asserting mid-compare is a protocol violation; its behaviour is undefined.
- REPORT:
  - Hold result_valid, result_ch and result_seq until result_valid && result_ready.
  - On acceptance, result_valid<=0. Continuous -> SELECT; otherwise -> DRAIN.
  - No pops while in REPORT.

Decomposition:
- Package hash_cmp_pkg: state enum (DRAIN, LOAD, SELECT, COMPARE, REPORT), parameter checks, NW/NC helper functions.
- One sub-module, rr_pick: combinational round-robin first-non-empty finder (req vector, pointer -> grant index and any_valid).

Test Plan:
- Reset/drain: rst_n=0 for 2 cycles, then hash_empty=4'b0101, all_empty=0 -> hash_re=4'b1010, stop_ack=0. Set all_empty=1 -> stop_ack=1, hash_re=0.
- Target load: after start, write words 0x11111111..0x88888888 (8 writes) with target_we gaps -> target_reg = 0x8888...1111. A ninth target_we is ignored.
- Early exit: target MSB chunk 0x10..0, ch2 head MSB chunk 0x0F.. -> golden after 1 COMPARE cycle; result_ch=2, result_seq=1; hash_re[2] pulses once.
- Equality and last chunk: head == target -> not golden after 4 COMPARE cycles and popped. Head == target-1 -> golden only on chunk 3.
- Round-robin/continuous: continuous=1, all 4 channels hold non-golden hashes -> service order 0,1,2,3,0. A golden hash on ch1 with result_ready low for 5 cycles -> result stays stable and no pops; after accept, resume at ch2.
- Stop mid-compare: stop=1 during COMPARE chunk 1 -> no pop, DRAIN next cycle, result_valid=0, stop_ack once all_empty.
